// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, optional 2-entry
// skid buffer, synchronous flush and bubble insertion with zeroed control.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W  = 12,
  parameter int unsigned DATA_W  = 64 + 64 + 64 + 64 + 15,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_v_q, main_v_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_v_q, skid_v_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept;
  logic              consume;

  always_comb begin
    // With the skid present, in_ready comes only from flops to cut the ready chain.
    if (SKID_EN) in_ready = reset & ~skid_v_q;
    else         in_ready = reset & (~main_v_q | out_ready);
  end

  assign accept    = in_valid & in_ready;
  assign consume   = main_v_q & out_ready;
  assign out_valid = main_v_q;
  assign out_ctrl  = main_v_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = 2'(main_v_q) + 2'(skid_v_q);

  always_comb begin
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (!main_v_q || consume) begin
      if (skid_v_q) begin
        main_v_d    = 1'b1;
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
        skid_v_d    = accept;
        if (accept) begin
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end
      end else if (accept) begin
        main_v_d    = 1'b1;
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept && SKID_EN) begin
      skid_v_d    = 1'b1;
      skid_ctrl_d = in_ctrl;
      skid_data_d = in_data;
    end

    // Flush squashes everything, including a same-cycle accept; data is left as-is.
    if (flush) begin
      main_v_d    = 1'b0;
      skid_v_d    = 1'b0;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID_EN=1 and SKID_EN=0 instances share stimulus;
// a queue scoreboard checks both every cycle, a vector table checks the skid instance.
module tb_pipe_stage_reg;
  localparam int CW = 12;
  localparam int DW = 64 + 64 + 64 + 64 + 15;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready_w  [2];
  logic          out_valid_w [2];
  logic [CW-1:0] out_ctrl_w  [2];
  logic [DW-1:0] out_data_w  [2];
  logic [1:0]    occ_w       [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0)) u_skid0 (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_ctrl(out_ctrl_w[0]),
    .out_data(out_data_w[0]), .occupancy(occ_w[0])
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1)) u_skid1 (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_ctrl(out_ctrl_w[1]),
    .out_data(out_data_w[1]), .occupancy(occ_w[1])
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Scoreboard: entries pushed on expected accept, popped on expected consume.
  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          sb [2][$];
  logic [DW-1:0] last_d [2];
  logic          mon_en = 1'b0;
  logic [1:0]    max_occ0 = '0;

  always @(negedge clk) begin
    int   sz;
    logic er;
    ent_t e;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        sz = sb[k].size();
        er = rst_n && ((k == 1) ? (sz < 2) : (sz == 0 || out_ready));
        chk($sformatf("sb%0d_in_ready", k), DW'(in_ready_w[k]), DW'(er));
        chk($sformatf("sb%0d_out_valid", k), DW'(out_valid_w[k]), DW'(sz > 0));
        chk($sformatf("sb%0d_out_ctrl", k), DW'(out_ctrl_w[k]),
            (sz > 0) ? DW'(sb[k][0].c) : '0);
        chk($sformatf("sb%0d_out_data", k), out_data_w[k],
            (sz > 0) ? sb[k][0].d : last_d[k]);
        chk($sformatf("sb%0d_occupancy", k), DW'(occ_w[k]), DW'(sz));
        if (!rst_n) begin
          sb[k].delete();
          last_d[k] = '0;
        end else if (flush) begin
          sb[k].delete();
        end else begin
          if (sz > 0 && out_ready) e = sb[k].pop_front();
          if (in_valid && er) sb[k].push_back('{c: in_ctrl, d: in_data});
        end
        if (sb[k].size() > 0) last_d[k] = sb[k][0].d;
      end
      if (occ_w[0] > max_occ0) max_occ0 = occ_w[0];
    end
  end

  // Directed vectors for the skid instance; expectations are post-edge state.
  typedef struct {
    logic          rst_n, flush, iv;
    logic [CW-1:0] c;
    logic [15:0]   d;
    logic          ordy;
    logic          e_v;
    logic [1:0]    e_occ;
    logic          e_rdy;
    logic [CW-1:0] e_c;
    logic [15:0]   e_d;
  } vec_t;

  vec_t vt[$];

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [CW-1:0] c, input logic [DW-1:0] d, input logic ordy);
    rst_n = r; flush = f; in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy;
  endtask

  initial begin
    last_d[0] = '0;
    last_d[1] = '0;
    //               rst fl iv ctrl    data      ordy  v  occ rdy ctrl    data
    vt.push_back('{1'b0,1'b0,1'b1,12'h005,16'h0005,1'b0, 1'b0,2'd0,1'b0,12'h000,16'h0000});
    vt.push_back('{1'b0,1'b0,1'b1,12'h005,16'h0005,1'b0, 1'b0,2'd0,1'b0,12'h000,16'h0000});
    vt.push_back('{1'b1,1'b0,1'b0,12'h000,16'h0000,1'b1, 1'b0,2'd0,1'b1,12'h000,16'h0000});
    vt.push_back('{1'b1,1'b0,1'b1,12'h001,16'h0001,1'b1, 1'b1,2'd1,1'b1,12'h001,16'h0001});
    vt.push_back('{1'b1,1'b0,1'b1,12'h002,16'h0002,1'b1, 1'b1,2'd1,1'b1,12'h002,16'h0002});
    vt.push_back('{1'b1,1'b0,1'b1,12'h003,16'h0003,1'b1, 1'b1,2'd1,1'b1,12'h003,16'h0003});
    vt.push_back('{1'b1,1'b0,1'b1,12'h004,16'h0004,1'b1, 1'b1,2'd1,1'b1,12'h004,16'h0004});
    vt.push_back('{1'b1,1'b0,1'b0,12'h000,16'h0000,1'b1, 1'b0,2'd0,1'b1,12'h000,16'h0004});
    vt.push_back('{1'b1,1'b0,1'b0,12'h000,16'h0000,1'b1, 1'b0,2'd0,1'b1,12'h000,16'h0004});
    vt.push_back('{1'b1,1'b0,1'b0,12'h000,16'h0000,1'b1, 1'b0,2'd0,1'b1,12'h000,16'h0004});
    vt.push_back('{1'b1,1'b0,1'b1,12'h005,16'h0005,1'b1, 1'b1,2'd1,1'b1,12'h005,16'h0005});
    vt.push_back('{1'b1,1'b0,1'b0,12'h000,16'h0000,1'b1, 1'b0,2'd0,1'b1,12'h000,16'h0005});
    vt.push_back('{1'b1,1'b0,1'b1,12'h00A,16'h000A,1'b0, 1'b1,2'd1,1'b1,12'h00A,16'h000A});
    vt.push_back('{1'b1,1'b0,1'b1,12'h00B,16'h000B,1'b0, 1'b1,2'd2,1'b0,12'h00A,16'h000A});
    vt.push_back('{1'b1,1'b0,1'b1,12'h00C,16'h000C,1'b0, 1'b1,2'd2,1'b0,12'h00A,16'h000A});
    vt.push_back('{1'b1,1'b0,1'b1,12'h00C,16'h000C,1'b1, 1'b1,2'd1,1'b1,12'h00B,16'h000B});
    vt.push_back('{1'b1,1'b0,1'b1,12'h00C,16'h000C,1'b1, 1'b1,2'd1,1'b1,12'h00C,16'h000C});
    vt.push_back('{1'b1,1'b0,1'b0,12'h000,16'h0000,1'b1, 1'b0,2'd0,1'b1,12'h000,16'h000C});
    vt.push_back('{1'b1,1'b0,1'b1,12'hFFF,16'h0010,1'b0, 1'b1,2'd1,1'b1,12'hFFF,16'h0010});
    vt.push_back('{1'b1,1'b0,1'b1,12'hFFF,16'h0011,1'b0, 1'b1,2'd2,1'b0,12'hFFF,16'h0010});
    vt.push_back('{1'b1,1'b1,1'b1,12'hFFF,16'h0012,1'b0, 1'b0,2'd0,1'b1,12'h000,16'h0010});
    vt.push_back('{1'b1,1'b0,1'b0,12'h000,16'h0000,1'b1, 1'b0,2'd0,1'b1,12'h000,16'h0010});
    vt.push_back('{1'b1,1'b0,1'b1,12'h020,16'h0020,1'b1, 1'b1,2'd1,1'b1,12'h020,16'h0020});
    vt.push_back('{1'b1,1'b0,1'b0,12'h000,16'h0000,1'b1, 1'b0,2'd0,1'b1,12'h000,16'h0020});

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst_n, vt[i].flush, vt[i].iv, vt[i].c, DW'(vt[i].d), vt[i].ordy);
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      chk($sformatf("vec%0d_out_valid", i), DW'(out_valid_w[1]), DW'(vt[i].e_v));
      chk($sformatf("vec%0d_occupancy", i), DW'(occ_w[1]), DW'(vt[i].e_occ));
      chk($sformatf("vec%0d_in_ready", i), DW'(in_ready_w[1]), DW'(vt[i].e_rdy));
      chk($sformatf("vec%0d_out_ctrl", i), DW'(out_ctrl_w[1]), DW'(vt[i].e_c));
      chk($sformatf("vec%0d_out_data", i), out_data_w[1], DW'(vt[i].e_d));
      #1;
    end

    // Combinational in_ready from out_ready when there is no skid buffer.
    drive(1'b1, 1'b0, 1'b1, 12'h030, DW'(16'h0030), 1'b0);
    @(posedge clk);
    #2;
    drive(1'b1, 1'b0, 1'b0, 12'h000, '0, 1'b1);
    #1;
    chk("skid0_ready_follows_out_ready_hi", DW'(in_ready_w[0]), DW'(1'b1));
    out_ready = 1'b0;
    #1;
    chk("skid0_ready_follows_out_ready_lo", DW'(in_ready_w[0]), DW'(1'b0));
    chk("skid1_ready_registered", DW'(in_ready_w[1]), DW'(1'b1));
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Random traffic with stalls, bubbles, flushes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0), CW'($urandom()),
            DW'({$urandom(), $urandom()}), ($urandom_range(0, 2) != 0));
      @(posedge clk);
      #2;
    end

    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("skid0_max_occupancy", DW'(max_occ0), DW'(2'd1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that supersedes the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. It carries a control bundle and a data bundle of configurable widths and adds what the fixed latches lack: a valid/ready handshake for stalls, an optional 2-entry skid buffer that breaks the combinational ready path, a synchronous flush for branch squash, and bubble insertion with zeroed control. It sits between every pair of adjacent core stages.

## Interface
- CTRL_W, 12, width of the control bundle (mem_to_reg, reg_write_en, alu_control, etc. packed by the instantiating stage)
- DATA_W, 64+64+64+64+15, width of the data bundle (pc, operands, immediate, register addresses)
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-low reset; sampled on rising clk
- flush  input  1  squash all held entries at the next edge
- in_valid  input  1  upstream stage presents an entry
- in_ready  output  1  block accepts an entry this cycle
- in_ctrl  input  CTRL_W  control bundle of the incoming entry
- in_data  input  DATA_W  data bundle of the incoming entry
- out_valid  output  1  downstream sees a valid entry
- out_ready  input  1  downstream consumes the entry this cycle
- out_ctrl  output  CTRL_W  control of the head entry; all zero when out_valid=0
- out_data  output  DATA_W  data of the head entry; holds last loaded value when out_valid=0
- occupancy  output  2  number of valid entries held (0..2; max 1 when SKID_EN=0)

## Operation
- Storage: main register (main_v, main_ctrl, main_data) drives outputs; skid register (skid_v, skid_ctrl, skid_data) exists only when SKID_EN=1.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready. out_valid = main_v.
- in_ready: SKID_EN=1: reset & ~skid_v (registered state only). SKID_EN=0: reset & (~main_v | out_ready).
- Update when main empty or consumed: main loads skid if skid_v (skid_v then clears, and an Accept in the same cycle refills skid); otherwise main loads the input if Accept; otherwise main_v clears.
- Update when main full and not consumed: Accept writes the skid (SKID_EN=1 only; in_ready blocks it when SKID_EN=0).
- Order is strictly FIFO; no entry is dropped or duplicated outside flush.
- Bubble: out_ctrl = main_v ? main_ctrl : 0, so an invalid stage never asserts a write or memory enable downstream.
- Flush (reset high): main_v and skid_v clear at the edge; an input accepted in the same cycle is discarded; data registers keep their values; the ctrl registers clear.
- Reset low at an edge: all valid bits, ctrl and data registers go to 0, with priority over flush and the handshake. While reset is low, in_ready=0.
- occupancy = main_v + skid_v.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0; in_ready=1 from the first cycle after reset goes high.
- Latency: 1 cycle from Accept to out_valid. Throughput: 1 entry/cycle with out_ready held high.
- SKID_EN=1: in_ready depends only on flops. It drops the cycle after a stall fills the skid and rises the cycle after the skid drains into main.
- SKID_EN=0: in_ready has a combinational path from out_ready.
- Stall then release: held entries leave in order on consecutive cycles.
- Flush during a stall with occupancy=2: occupancy=0, out_valid=0 and in_ready=1 on the next cycle.
- Simultaneous Accept and Consume with occupancy=1: main is replaced and occupancy stays 1.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=0; release -> in_ready=1 on the next cycle.
- Streaming: send data 1,2,3,4 back-to-back with out_ready=1 -> out_data shows 1,2,3,4 on consecutive cycles, each 1 cycle after Accept, occupancy=1.
- Stall (SKID_EN=1): send 0xA,0xB,0xC with out_ready=0 -> 0xA in main, 0xB in skid, in_ready=0, 0xC held upstream; raise out_ready -> 0xA,0xB,0xC out in order with no gaps.
- Flush: occupancy=2, ctrl=0xFFF, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; the flushed-cycle input never appears.
- Bubble: in_valid=0 for 3 cycles mid-stream -> out_valid=0 and out_ctrl=0 for exactly those 3 cycles, and out_data holds the last value.
- SKID_EN=0: drop out_ready with main full -> in_ready falls in the same cycle; occupancy never exceeds 1; ordering preserved.
